// File: rtl/loop_nest_monitor.sv
// Receive-side checker for the nested-loop sequencer: rebuilds (x, y) from the
// action counter, flags jumps, short passes and overruns, and counts good passes.
module loop_nest_monitor #(
    parameter int OUTER = 10,
    parameter int INNER = 10,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] act_in,
    input  logic         err_clr,
    output logic [7:0]   x_idx,
    output logic [7:0]   y_idx,
    output logic         step,
    output logic         pass_done,
    output logic [15:0]  pass_cnt,
    output logic         err,
    output logic [1:0]   err_code
);

    localparam int TOTAL = OUTER * INNER;
    localparam int SW    = $clog2(TOTAL + 1);
    localparam logic [SW-1:0] TOTAL_C = SW'(TOTAL);
    localparam logic [7:0]    Y_LAST  = 8'(INNER - 1);

    typedef enum logic [1:0] {EV_HOLD, EV_END, EV_STEP, EV_JUMP} event_t;
    typedef enum logic [1:0] {
        CODE_NONE  = 2'd0,
        CODE_JUMP  = 2'd1,
        CODE_SHORT = 2'd2,
        CODE_OVER  = 2'd3
    } code_t;

    logic [W-1:0]  act_q;
    logic [W-1:0]  act_inc;
    logic [7:0]    x_cnt;
    logic [7:0]    y_cnt;
    logic [SW-1:0] step_cnt;
    logic          full;
    event_t        ev;
    code_t         new_code;

    assign act_inc = act_q + W'(1);
    assign full    = (step_cnt == TOTAL_C);

    // Classify this sample against the previous one; earlier tests take priority.
    always_comb begin
        ev       = EV_JUMP;
        new_code = CODE_NONE;
        if (act_in == act_q)
            ev = EV_HOLD;
        else if (act_in == '0)
            ev = EV_END;
        else if (act_in == act_inc)
            ev = EV_STEP;

        case (ev)
            EV_END:  if (!full) new_code = CODE_SHORT;
            EV_STEP: if (full)  new_code = CODE_OVER;
            EV_JUMP: new_code = CODE_JUMP;
            default: new_code = CODE_NONE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_q     <= '0;
            x_cnt     <= '0;
            y_cnt     <= '0;
            step_cnt  <= '0;
            x_idx     <= '0;
            y_idx     <= '0;
            step      <= 1'b0;
            pass_done <= 1'b0;
            pass_cnt  <= '0;
            err       <= 1'b0;
            err_code  <= 2'd0;
        end else begin
            act_q     <= act_in;
            step      <= 1'b0;
            pass_done <= 1'b0;

            case (ev)
                EV_STEP: begin
                    if (!full) begin
                        step     <= 1'b1;
                        x_idx    <= x_cnt;
                        y_idx    <= y_cnt;
                        step_cnt <= step_cnt + SW'(1);
                        if (y_cnt == Y_LAST) begin
                            y_cnt <= '0;
                            x_cnt <= x_cnt + 8'd1;
                        end else begin
                            y_cnt <= y_cnt + 8'd1;
                        end
                    end
                end
                EV_END: begin
                    if (full) begin
                        pass_done <= 1'b1;
                        pass_cnt  <= pass_cnt + 16'd1;
                    end
                    x_cnt    <= '0;
                    y_cnt    <= '0;
                    step_cnt <= '0;
                end
                default: ;
            endcase

            // First error is sticky, but a clear in the same cycle lets a new one in.
            if (new_code != CODE_NONE) begin
                if (!err || err_clr) begin
                    err      <= 1'b1;
                    err_code <= new_code;
                end
            end else if (err_clr) begin
                err      <= 1'b0;
                err_code <= 2'd0;
            end
        end
    end

endmodule

// File: tb/tb_loop_nest_monitor.sv
// Directed bench for loop_nest_monitor: a behavioural model pushes expected
// outputs into a scoreboard queue that is popped after each clock edge.
module tb_loop_nest_monitor;

    localparam int OUTER = 10;
    localparam int INNER = 10;
    localparam int W     = 8;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] act_in;
    logic         err_clr;
    logic [7:0]   x_idx;
    logic [7:0]   y_idx;
    logic         step;
    logic         pass_done;
    logic [15:0]  pass_cnt;
    logic         err;
    logic [1:0]   err_code;

    typedef struct {
        logic        step;
        logic        pd;
        logic [7:0]  x;
        logic [7:0]  y;
        logic [15:0] pc;
        logic        err;
        logic [1:0]  code;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int passed = 0;

    // Model state
    int          m_actq;
    int          m_steps;
    logic [7:0]  m_x;
    logic [7:0]  m_y;
    logic [15:0] m_pass;
    logic        m_err;
    logic [1:0]  m_code;

    loop_nest_monitor #(.OUTER(OUTER), .INNER(INNER), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .act_in    (act_in),
        .err_clr   (err_clr),
        .x_idx     (x_idx),
        .y_idx     (y_idx),
        .step      (step),
        .pass_done (pass_done),
        .pass_cnt  (pass_cnt),
        .err       (err),
        .err_code  (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_actq  = 0;
        m_steps = 0;
        m_x     = '0;
        m_y     = '0;
        m_pass  = '0;
        m_err   = 1'b0;
        m_code  = 2'd0;
    endtask

    task automatic checkZeros(input string tag);
        chk({tag, ".x"},    16'(x_idx),     16'd0);
        chk({tag, ".y"},    16'(y_idx),     16'd0);
        chk({tag, ".step"}, 16'(step),      16'd0);
        chk({tag, ".pd"},   16'(pass_done), 16'd0);
        chk({tag, ".pc"},   pass_cnt,       16'd0);
        chk({tag, ".err"},  16'(err),       16'd0);
        chk({tag, ".code"}, 16'(err_code),  16'd0);
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 16'd1, 16'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, ".step"}, 16'(step),      16'(e.step));
            chk({tag, ".pd"},   16'(pass_done), 16'(e.pd));
            chk({tag, ".x"},    16'(x_idx),     16'(e.x));
            chk({tag, ".y"},    16'(y_idx),     16'(e.y));
            chk({tag, ".pc"},   pass_cnt,       e.pc);
            chk({tag, ".err"},  16'(err),       16'(e.err));
            chk({tag, ".code"}, 16'(err_code),  16'(e.code));
        end
    endtask

    task automatic applyStimulus(input int act, input logic clr, input string tag);
        exp_t e;
        int   code;
        @(negedge clk);
        act_in  = W'(act);
        err_clr = clr;
        e.step = 1'b0;
        e.pd   = 1'b0;
        code   = 0;
        if (act == m_actq) begin
            code = 0;
        end else if (act == 0) begin
            if (m_steps == OUTER * INNER) begin
                e.pd   = 1'b1;
                m_pass = m_pass + 16'd1;
            end else begin
                code = 2;
            end
            m_steps = 0;
        end else if (act == ((m_actq + 1) % (1 << W))) begin
            if (m_steps == OUTER * INNER) begin
                code = 3;
            end else begin
                e.step  = 1'b1;
                m_x     = 8'(m_steps / INNER);
                m_y     = 8'(m_steps % INNER);
                m_steps = m_steps + 1;
            end
        end else begin
            code = 1;
        end
        if (code != 0) begin
            if (!m_err || clr) begin
                m_err  = 1'b1;
                m_code = 2'(code);
            end
        end else if (clr) begin
            m_err  = 1'b0;
            m_code = 2'd0;
        end
        m_actq = act;
        e.x    = m_x;
        e.y    = m_y;
        e.pc   = m_pass;
        e.err  = m_err;
        e.code = m_code;
        sb.push_back(e);
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        rst_n   = 1'b0;
        act_in  = W'(37);
        err_clr = 1'b0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checkZeros("reset");
        @(negedge clk);
        act_in = '0;
        rst_n  = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(0, 1'b0, "idle");

        $display("[TB] good pass");
        for (int i = 1; i <= 100; i++) begin
            applyStimulus(i, 1'b0, "good");
            if (i == 1)   begin chk("good.s1x", 16'(x_idx), 16'd0); chk("good.s1y", 16'(y_idx), 16'd0); end
            if (i == 11)  begin chk("good.s11x", 16'(x_idx), 16'd1); chk("good.s11y", 16'(y_idx), 16'd0); end
            if (i == 100) begin chk("good.s100x", 16'(x_idx), 16'd9); chk("good.s100y", 16'(y_idx), 16'd9); end
        end
        applyStimulus(0, 1'b0, "good_end");
        chk("good.pd", 16'(pass_done), 16'd1);
        chk("good.pc", pass_cnt, 16'd1);
        chk("good.err", 16'(err), 16'd0);
        applyStimulus(0, 1'b0, "good_hold");
        chk("good.pd_once", 16'(pass_done), 16'd0);

        $display("[TB] jump");
        applyStimulus(1, 1'b0, "jump");
        applyStimulus(2, 1'b0, "jump");
        applyStimulus(5, 1'b0, "jump5");
        chk("jump.err", 16'(err), 16'd1);
        chk("jump.code", 16'(err_code), 16'd1);
        chk("jump.nostep", 16'(step), 16'd0);
        applyStimulus(6, 1'b0, "jump6");
        chk("jump.resync", 16'(step), 16'd1);
        chk("jump.y", 16'(y_idx), 16'd2);
        applyStimulus(0, 1'b0, "jump_end");
        chk("jump.sticky", 16'(err_code), 16'd1);
        applyStimulus(0, 1'b1, "clear");
        chk("clear.err", 16'(err), 16'd0);

        $display("[TB] short");
        for (int i = 1; i <= 50; i++) applyStimulus(i, 1'b0, "short");
        applyStimulus(0, 1'b0, "short_end");
        chk("short.code", 16'(err_code), 16'd2);
        chk("short.pd", 16'(pass_done), 16'd0);
        chk("short.pc", pass_cnt, 16'd1);
        for (int i = 1; i <= 100; i++) applyStimulus(i, 1'b0, "after_short");
        applyStimulus(0, 1'b0, "after_short_end");
        chk("after_short.pd", 16'(pass_done), 16'd1);
        chk("after_short.pc", pass_cnt, 16'd2);
        chk("after_short.code", 16'(err_code), 16'd2);
        applyStimulus(0, 1'b1, "clear2");

        $display("[TB] over");
        for (int i = 1; i <= 101; i++) applyStimulus(i, 1'b0, "over");
        chk("over.code", 16'(err_code), 16'd3);
        chk("over.nostep", 16'(step), 16'd0);
        chk("over.x", 16'(x_idx), 16'd9);
        applyStimulus(0, 1'b0, "over_end");
        chk("over.pd", 16'(pass_done), 16'd1);
        chk("over.pc", pass_cnt, 16'd3);
        applyStimulus(0, 1'b1, "clear3");

        $display("[TB] clear collision");
        for (int i = 1; i <= 3; i++) applyStimulus(i, 1'b0, "coll");
        applyStimulus(0, 1'b0, "coll_short");
        chk("coll.pre", 16'(err_code), 16'd2);
        applyStimulus(5, 1'b1, "coll_jump");
        chk("coll.err", 16'(err), 16'd1);
        chk("coll.code", 16'(err_code), 16'd1);
        applyStimulus(5, 1'b1, "coll_clr");
        chk("coll.clr_err", 16'(err), 16'd0);
        chk("coll.clr_code", 16'(err_code), 16'd0);
        applyStimulus(6, 1'b0, "mid");
        applyStimulus(7, 1'b0, "mid");

        $display("[TB] reset mid-pass");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkZeros("midreset");
        @(negedge clk);
        act_in = '0;
        rst_n  = 1'b1;
        modelReset();
        applyStimulus(1, 1'b0, "post_reset");
        chk("post_reset.step", 16'(step), 16'd1);
        applyStimulus(2, 1'b0, "post_reset");
        chk("post_reset.y", 16'(y_idx), 16'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
